reg_file_mp: RTL and testbench

Parametrised multi-port register file for the next-generation MIPS core. It generalises the single 2R/1W file to NUM_RD read ports and NUM_WR write ports. It adds a hardwired zero register, optional write-to-read bypass, and a per-register busy scoreboard for multi-cycle producers such as mul/div and loads. It sits between decode (reads, busy checks) and writeback (writes, busy clear).

---
 rtl/reg_file_mp_pkg.sv | 22 ++
 rtl/reg_file_mp_if.sv | 29 ++
 rtl/reg_file_mp_scoreboard.sv | 58 +++++
 rtl/reg_file_mp.sv | 84 ++++++++
 tb/tb_reg_file_mp.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared constants and helpers for the multi-port register file slice.
// Defaults, the zero-register address and the write-port priority resolver.
package reg_file_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int NUM_RD_DEF = 2;
    localparam int NUM_WR_DEF = 2;
    localparam int ZERO_ADDR  = 0;
    localparam int MAX_PORTS  = 32;

    // Highest-index set bit wins; -1 when nothing matches.
    function automatic int last_match(input logic [MAX_PORTS-1:0] hits);
        int idx;
        idx = -1;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (hits[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus of the multi-port register file.
// The master drives addresses, write data and scoreboard sets; the slave answers.
interface reg_file_mp_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) ();

    logic [NUM_RD*ADDR_W-1:0] RA;
    logic [NUM_RD*DATA_W-1:0] RD;
    logic [NUM_RD-1:0]        RBUSY;
    logic [NUM_WR-1:0]        WE;
    logic [NUM_WR*ADDR_W-1:0] WA;
    logic [NUM_WR*DATA_W-1:0] WD;
    logic                     SB_SET;
    logic [ADDR_W-1:0]        SB_ADDR;

    modport master (
        output RA, WE, WA, WD, SB_SET, SB_ADDR,
        input  RD, RBUSY
    );

    modport slave (
        input  RA, WE, WA, WD, SB_SET, SB_ADDR,
        output RD, RBUSY
    );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy bits for long-latency producers, with set-over-clear
// priority and a per-read-port busy lookup that can see this cycle's clears.
module reg_file_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    input  logic [NUM_WR-1:0]        wr_ok,
    input  logic [NUM_WR*ADDR_W-1:0] wa,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    output logic [NUM_RD-1:0]        rbusy
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] set_v;
    logic [DEPTH-1:0] clr_v;
    logic             set_ok;

    assign set_ok = RST && sb_set && (int'(sb_addr) < DEPTH)
                    && !(ZERO_REG && sb_addr == ADDR_W'(0));

    always_comb begin
        set_v = '0;
        clr_v = '0;
        if (set_ok) set_v[sb_addr] = 1'b1;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_ok[p]) clr_v[wa[p*ADDR_W +: ADDR_W]] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_v) | set_v;
        end
    end

    // A clear that is not overridden by a fresh set looks already done when bypassing.
    always_comb begin
        logic [ADDR_W-1:0] a;
        rbusy = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            a = ra[r*ADDR_W +: ADDR_W];
            if (RST && int'(a) < DEPTH && !(ZERO_REG && a == ADDR_W'(0))) begin
                rbusy[r] = busy[a] && !(BYPASS && clr_v[a] && !set_v[a]);
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised NUM_RD-read / NUM_WR-write register file with optional zero
// register, write-to-read bypass and a busy scoreboard for multi-cycle producers.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 2**ADDR_W,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int NUM_WR   = NUM_WR_DEF,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic         CLK,
    input  logic         RST,
    reg_file_mp_if.slave bus
);

    logic [DATA_W-1:0]        mem [DEPTH];
    logic [NUM_WR-1:0]        wr_ok;
    logic [NUM_RD*DATA_W-1:0] rd_flat;

    // Dropped writes (reset, out of range, zero register) never reach the array or bypass.
    always_comb begin
        logic [ADDR_W-1:0] a;
        wr_ok = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            a = bus.WA[p*ADDR_W +: ADDR_W];
            wr_ok[p] = RST && bus.WE[p] && (int'(a) < DEPTH)
                       && !(ZERO_REG && a == ADDR_W'(ZERO_ADDR));
        end
    end

    // Later ports in the loop overwrite earlier ones, so the highest index wins.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_ok[p]) mem[bus.WA[p*ADDR_W +: ADDR_W]] <= bus.WD[p*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0]    a;
        logic [MAX_PORTS-1:0] hits;
        int                   idx;
        rd_flat = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            a    = bus.RA[r*ADDR_W +: ADDR_W];
            hits = '0;
            for (int p = 0; p < NUM_WR; p++) begin
                hits[p] = wr_ok[p] && (bus.WA[p*ADDR_W +: ADDR_W] == a);
            end
            idx = last_match(hits);
            if (RST && int'(a) < DEPTH && !(ZERO_REG && a == ADDR_W'(ZERO_ADDR))) begin
                if (BYPASS && idx >= 0) rd_flat[r*DATA_W +: DATA_W] = bus.WD[idx*DATA_W +: DATA_W];
                else                    rd_flat[r*DATA_W +: DATA_W] = mem[a];
            end
        end
    end

    assign bus.RD = rd_flat;

    reg_file_scoreboard #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .NUM_RD  (NUM_RD),
        .NUM_WR  (NUM_WR),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_sb (
        .CLK    (CLK),
        .RST    (RST),
        .ra     (bus.RA),
        .wr_ok  (wr_ok),
        .wa     (bus.WA),
        .sb_set (bus.SB_SET),
        .sb_addr(bus.SB_ADDR),
        .rbusy  (bus.RBUSY)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: one non-bypassing file with DEPTH=28 and one bypassing full-depth
// file driven by the same stimulus, checked against hand-computed values.
module tb_reg_file_mp;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [9:0]  ra;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [63:0] rd0, rd1;
    logic [1:0]  rb0, rb1;
    int          checks = 0;
    int          errors = 0;

    always #5 CLK = ~CLK;

    reg_file_mp_if #(.ADDR_W(5), .DATA_W(32), .NUM_RD(2), .NUM_WR(2)) if0 ();
    reg_file_mp_if #(.ADDR_W(5), .DATA_W(32), .NUM_RD(2), .NUM_WR(2)) if1 ();

    assign if0.RA = ra;  assign if0.WE = we;  assign if0.WA = wa;  assign if0.WD = wd;
    assign if0.SB_SET = sb_set;  assign if0.SB_ADDR = sb_addr;
    assign if1.RA = ra;  assign if1.WE = we;  assign if1.WA = wa;  assign if1.WD = wd;
    assign if1.SB_SET = sb_set;  assign if1.SB_ADDR = sb_addr;
    assign rd0 = if0.RD;  assign rb0 = if0.RBUSY;
    assign rd1 = if1.RD;  assign rb1 = if1.RBUSY;

    reg_file_mp #(.ADDR_W(5), .DATA_W(32), .DEPTH(28), .NUM_RD(2), .NUM_WR(2),
                  .ZERO_REG(1'b1), .BYPASS(1'b0)) dut0 (.CLK(CLK), .RST(RST), .bus(if0));
    reg_file_mp #(.ADDR_W(5), .DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2),
                  .ZERO_REG(1'b1), .BYPASS(1'b1)) dut1 (.CLK(CLK), .RST(RST), .bus(if1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        we = '0; wa = '0; wd = '0; sb_set = 1'b0; sb_addr = '0;
    endtask

    initial begin
        idle();
        ra = {5'd5, 5'd5};
        tick(); tick();
        chk("rst_rd0_nb",  rd0[31:0], 32'h0);
        chk("rst_rd0_byp", rd1[31:0], 32'h0);
        chk("rst_rb_nb",   {30'h0, rb0}, 32'h0);
        RST = 1'b1;

        // 1: write reg5, busy reg6, then asynchronous reset pulse between edges
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEADBEEF};
        sb_set = 1'b1; sb_addr = 5'd6;
        tick(); idle();
        ra = {5'd6, 5'd5};
        #1;
        chk("t1_stored",  rd0[31:0], 32'hDEADBEEF);
        chk("t1_busy6",   {31'h0, rb0[1]}, 32'h1);
        #1 RST = 1'b0;
        #1;
        chk("t1_arst_rd_nb",  rd0[31:0], 32'h0);
        chk("t1_arst_rd_byp", rd1[31:0], 32'h0);
        chk("t1_arst_rb_nb",  {30'h0, rb0}, 32'h0);
        chk("t1_arst_rb_byp", {30'h0, rb1}, 32'h0);
        #1 RST = 1'b1;
        tick();
        chk("t1_after_rd",  rd1[31:0], 32'h0);
        chk("t1_after_rb",  {30'h0, rb1}, 32'h0);

        // 2: basic write, visible next cycle on both read ports
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h12345678};
        ra = {5'd3, 5'd3};
        #1;
        chk("t2_same_nb",  rd0[31:0], 32'h0);
        chk("t2_same_byp", rd1[31:0], 32'h12345678);
        tick(); idle();
        chk("t2_nb_p0",  rd0[31:0],  32'h12345678);
        chk("t2_nb_p1",  rd0[63:32], 32'h12345678);
        chk("t2_byp_p1", rd1[63:32], 32'h12345678);

        // 3: zero register ignores writes and scoreboard sets
        we = 2'b11; wa = {5'd0, 5'd0}; wd = {32'hFFFFFFFF, 32'hFFFFFFFF};
        sb_set = 1'b1; sb_addr = 5'd0; ra = {5'd3, 5'd0};
        #1;
        chk("t3_same_byp", rd1[31:0], 32'h0);
        chk("t3_same_rb",  {30'h0, rb1[0], rb0[0]}, 32'h0);
        chk("t3_port1",    rd1[63:32], 32'h12345678);
        tick(); idle();
        chk("t3_after_nb", rd0[31:0], 32'h0);
        chk("t3_after_rb", {30'h0, rb1[0], rb0[0]}, 32'h0);

        // 4: two ports write the same address, highest index wins
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11};
        ra = {5'd3, 5'd7};
        #1;
        chk("t4_same_byp", rd1[31:0], 32'h22);
        chk("t4_same_nb",  rd0[31:0], 32'h0);
        tick(); idle();
        chk("t4_after_nb",  rd0[31:0], 32'h22);
        chk("t4_after_byp", rd1[31:0], 32'h22);

        // 5: scoreboard set, then clear by writeback
        sb_set = 1'b1; sb_addr = 5'd9; ra = {5'd3, 5'd9};
        #1;
        chk("t5_set_cycle", {30'h0, rb1[0], rb0[0]}, 32'h0);
        tick(); idle();
        chk("t5_busy", {30'h0, rb1[0], rb0[0]}, 32'h3);
        chk("t5_port1_idle", {30'h0, rb1[1], rb0[1]}, 32'h0);
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'hABCD};
        #1;
        chk("t5_wr_rb_byp", {31'h0, rb1[0]}, 32'h0);
        chk("t5_wr_rb_nb",  {31'h0, rb0[0]}, 32'h1);
        chk("t5_wr_rd_byp", rd1[31:0], 32'hABCD);
        tick(); idle();
        chk("t5_after_rb", {30'h0, rb1[0], rb0[0]}, 32'h0);
        chk("t5_after_rd", rd0[31:0], 32'hABCD);

        // 6: set and clear together keep the bit busy
        sb_set = 1'b1; sb_addr = 5'd4; ra = {5'd9, 5'd4};
        tick(); idle();
        chk("t6_busy", {30'h0, rb1[0], rb0[0]}, 32'h3);
        we = 2'b01; wa = {5'd0, 5'd4}; wd = {32'h0, 32'h55};
        sb_set = 1'b1; sb_addr = 5'd4;
        #1;
        chk("t6_same_rb_byp", {31'h0, rb1[0]}, 32'h1);
        tick(); idle();
        chk("t6_rd_nb",  rd0[31:0], 32'h55);
        chk("t6_rd_byp", rd1[31:0], 32'h55);
        chk("t6_rb",     {30'h0, rb1[0], rb0[0]}, 32'h3);

        // out-of-range address on the 28-deep file; ordinary on the full-depth one
        we = 2'b10; wa = {5'd30, 5'd0}; wd = {32'h77, 32'h0};
        sb_set = 1'b1; sb_addr = 5'd30; ra = {5'd4, 5'd30};
        tick(); idle();
        chk("oor_rd_nb",  rd0[31:0], 32'h0);
        chk("oor_rb_nb",  {31'h0, rb0[0]}, 32'h0);
        chk("oor_rd_byp", rd1[31:0], 32'h77);
        chk("oor_rb_byp", {31'h0, rb1[0]}, 32'h1);
        chk("oor_port1",  rd0[63:32], 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
